// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default baud constants and a
// divider helper. Used by the transmitter and the receiver.
package uart_pkg;

  localparam int UART_CLK_HZ = 50_000_000;
  localparam int UART_BAUD   = 115200;

  // Transmit FSM states. ST_PARITY is only reached when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // System clocks per bit, rounded to the nearest integer.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider shared by the UART transmitter and receiver.
// Counts 0..CLK_DIV-1 while enabled; tick marks the last clock of a bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter: clr restarts a bit period, otherwise wrap at LAST.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: valid/ready word input, LSB-first serial frame
// (start, DATA_W data bits, optional parity, STOP_BITS stop bits) on ttl_tx_o.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data;
// PARITY_ODD selects odd (1) or even (0) parity.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = uart_div(UART_CLK_HZ, UART_BAUD),
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              ttl_tx_o
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_tx_state_t    state;
  logic [DATA_W-1:0] shift;
  logic [BIT_W-1:0]  bit_cnt;
  logic              tick;
  logic              accept;
  logic              frame_end;

`ifdef UART_TX_PARITY_EN
  // Running XOR of the bits already driven, seeded with the parity sense.
  logic              par;
  localparam logic PAR_SEED = (PARITY_ODD != 0);
`else
  logic              unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .clr   (accept),
    .tick  (tick)
  );

  // The last clock of the final stop bit both ends the frame and reopens the
  // input, so a waiting word starts its start bit on the very next clock.
  assign frame_end = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
  assign tx_ready  = (state == ST_IDLE) || frame_end;
  assign accept    = tx_valid && tx_ready;
  assign tx_done   = frame_end;
  assign tx_busy   = (state != ST_IDLE);

  // Frame sequencer: loads a word on acceptance and steps one bit per tick,
  // registering the line value for the bit that starts at that edge.
  // NOTE: the shift register is reset with the rest of the datapath; it is a
  // handful of flops, not a memory, and a known value keeps the line clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ttl_tx_o <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (accept) begin
      state    <= ST_START;
      ttl_tx_o <= 1'b0;
      shift    <= tx_data;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= PAR_SEED;
`endif
    end else if (tick) begin
      case (state)
        ST_START: begin
          state    <= ST_DATA;
          ttl_tx_o <= shift[0];
          shift    <= shift >> 1;
`ifdef UART_TX_PARITY_EN
          par      <= par ^ shift[0];
`endif
        end
        ST_DATA: begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            state    <= ST_PARITY;
            ttl_tx_o <= par;
`else
            state    <= ST_STOP;
            ttl_tx_o <= 1'b1;
`endif
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            ttl_tx_o <= shift[0];
            shift    <= shift >> 1;
`ifdef UART_TX_PARITY_EN
            par      <= par ^ shift[0];
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state    <= ST_STOP;
          ttl_tx_o <= 1'b1;
          bit_cnt  <= '0;
        end
`endif
        ST_STOP: begin
          if (bit_cnt == LAST_STOP) begin
            state <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ttl_tx_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Three instances at CLK_DIV = 4:
//   u0: DATA_W 8, 1 stop, even   u1: DATA_W 8, 2 stop, odd   u2: DATA_W 5, 1 stop
// Each has a frame-level model (bit list + cycle offset since acceptance)
// compared against the DUT on every falling edge.
module tb_uart_tx_frame;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] tx_valid;
  logic [2:0] tx_ready;
  logic [2:0] tx_busy;
  logic [2:0] tx_done;
  logic [2:0] ttl;
  logic [8:0] tx_data [3];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW  = (g == 2) ? 5 : 8;
    localparam int SB  = (g == 1) ? 2 : 1;
    localparam int ODD = (g == 1) ? 1 : 0;
    localparam int NB  = 1 + DW + P + SB;
    localparam int F   = NB * CD;

    uart_tx_frame #(
      .CLK_DIV    (CD),
      .DATA_W     (DW),
      .STOP_BITS  (SB),
      .PARITY_ODD (ODD)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data[g][DW-1:0]),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .tx_busy  (tx_busy[g]),
      .tx_done  (tx_done[g]),
      .ttl_tx_o (ttl[g])
    );

    // Model: t = clock cycles since acceptance (-1 when idle); fb = frame bits.
    int   t = -1;
    logic fb [16];

    always @(posedge clk or negedge rst_n) begin
      logic       rdy;
      logic [8:0] d;
      if (!rst_n) begin
        t = -1;
      end else begin
        rdy = (t < 0) || (t == F - 1);
        if (tx_valid[g] && rdy) begin
          d = tx_data[g];
          fb[0] = 1'b0;
          for (int k = 0; k < DW; k++) fb[1 + k] = d[k];
          if (P == 1) fb[1 + DW] = (^d[DW-1:0]) ^ (ODD != 0);
          for (int k = 0; k < SB; k++) fb[1 + DW + P + k] = 1'b1;
          t = 0;
        end else if (t >= 0) begin
          t = (t == F - 1) ? -1 : t + 1;
        end
      end
    end

    always @(negedge clk) begin
      logic e_line;
      if (chk_on) begin
        e_line = (t < 0) ? 1'b1 : fb[t / CD];
        check($sformatf("u%0d.ttl_tx_o", g), ttl[g], e_line);
        check($sformatf("u%0d.tx_ready", g), tx_ready[g], (t < 0) || (t == F - 1));
        check($sformatf("u%0d.tx_busy", g), tx_busy[g], t >= 0);
        check($sformatf("u%0d.tx_done", g), tx_done[g], t == F - 1);
      end
    end
  end

  // Present one word to an idle instance; returns just after the accepting edge.
  task automatic send(input int i, input logic [8:0] d);
    @(posedge clk);
    #1;
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[i] = 1'b0;
  endtask

  // Sample each bit mid-period and measure the frame length up to tx_done.
  task automatic observe(input int i, output logic [15:0] bits, output int flen);
    bits = '1;
    flen = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c % CD == 1) bits[c / CD] = ttl[i];
      if (tx_done[i]) begin
        flen = c + 1;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] bits;
    int          flen;

    tx_valid = '0;
    for (int i = 0; i < 3; i++) tx_data[i] = '0;

    #2 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset.
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle.u%0d.line", i), ttl[i], 1'b1);
      check($sformatf("idle.u%0d.ready", i), tx_ready[i], 1'b1);
      check($sformatf("idle.u%0d.busy", i), tx_busy[i], 1'b0);
    end

    // 0xA5 on u0.
    send(0, 9'h0A5);
    observe(0, bits, flen);
    check("u0.A5.start", bits[0], 1'b0);
    check("u0.A5.data", bits[8:1], 8'hA5);
    check("u0.A5.bit9", bits[9], (P == 1) ? 1'b0 : 1'b1);
    check("u0.A5.stop", bits[9 + P], 1'b1);
    check("u0.A5.len", flen, (P == 1) ? 44 : 40);

    // 0xA5 on u1 (odd parity, 2 stop bits).
    send(1, 9'h0A5);
    observe(1, bits, flen);
    check("u1.A5.data", bits[8:1], 8'hA5);
    check("u1.A5.bit9", bits[9], 1'b1);
    check("u1.A5.len", flen, (P == 1) ? 48 : 44);

    // 0x01 on u0 (even parity bit 1).
    send(0, 9'h001);
    observe(0, bits, flen);
    check("u0.01.data", bits[8:1], 8'h01);
    check("u0.01.bit9", bits[9], 1'b1);

    // 0x1F on u2 (DATA_W 5).
    send(2, 9'h01F);
    observe(2, bits, flen);
    check("u2.1F.start", bits[0], 1'b0);
    check("u2.1F.data", bits[5:1], 5'h1F);
    check("u2.1F.bit6", bits[6], 1'b1);
    check("u2.1F.len", flen, (P == 1) ? 32 : 28);

    // Back-to-back on u1: tx_valid held, tx_data changed while busy.
    @(posedge clk);
    #1;
    tx_data[1]  = 9'h055;
    tx_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    tx_data[1]  = 9'h00F;
    observe(1, bits, flen);
    check("b2b.first.data", bits[8:1], 8'h55);
    check("b2b.first.len", flen, (P == 1) ? 48 : 44);
    @(posedge clk);
    #1;
    tx_valid[1] = 1'b0;
    observe(1, bits, flen);
    check("b2b.second.start", bits[0], 1'b0);
    check("b2b.second.data", bits[8:1], 8'h0F);
    check("b2b.second.len", flen, (P == 1) ? 48 : 44);

    // Reset ten cycles into a frame on u0.
    send(0, 9'h03C);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst.line", ttl[0], 1'b1);
    check("rst.ready", tx_ready[0], 1'b1);
    check("rst.busy", tx_busy[0], 1'b0);
    check("rst.done", tx_done[0], 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_rst.line", ttl[0], 1'b1);
      check("post_rst.ready", tx_ready[0], 1'b1);
    end

    // Random traffic on all instances, checked by the models.
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        tx_valid[i] = ($urandom_range(0, 3) != 0);
        tx_data[i]  = 9'($urandom);
      end
    end
    @(posedge clk);
    #1 tx_valid = '0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
